// File: rtl/tour_pkg.sv
// Shared types and constants for knight's-tour command replay.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } state_t;

   localparam logic [3:0] OP_VERT = 4'b0100;
   localparam logic [3:0] OP_HORZ = 4'b0101;

   localparam logic [7:0] HEAD_N = 8'h00;
   localparam logic [7:0] HEAD_W = 8'h3F;
   localparam logic [7:0] HEAD_S = 8'h7F;
   localparam logic [7:0] HEAD_E = 8'hBF;

   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_ACK  = 8'h5A;

   localparam logic [4:0] LAST_MOVE = 5'd23;

endpackage

// File: rtl/knight_move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal leg commands.
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd,
   output logic        valid
);

   logic [7:0]        low;
   logic signed [2:0] dx;
   logic signed [2:0] dy;
   logic signed [2:0] mag_x;
   logic signed [2:0] mag_y;

   always_comb begin
      // Isolate the lowest set bit so multi-hot inputs resolve deterministically.
      low   = move & (~move + 8'd1);
      valid = 1'b1;
      dx    = 3'sd0;
      dy    = 3'sd0;
      case (low)
         8'h01:   begin dx =  3'sd1; dy =  3'sd2; end
         8'h02:   begin dx = -3'sd1; dy =  3'sd2; end
         8'h04:   begin dx = -3'sd2; dy =  3'sd1; end
         8'h08:   begin dx = -3'sd2; dy = -3'sd1; end
         8'h10:   begin dx = -3'sd1; dy = -3'sd2; end
         8'h20:   begin dx =  3'sd1; dy = -3'sd2; end
         8'h40:   begin dx =  3'sd2; dy = -3'sd1; end
         8'h80:   begin dx =  3'sd2; dy =  3'sd1; end
         default: valid = 1'b0;
      endcase
      mag_x    = dx[2] ? -dx : dx;
      mag_y    = dy[2] ? -dy : dy;
      vert_cmd = {OP_VERT, (dy[2] ? HEAD_S : HEAD_N), 1'b0, mag_y};
      horz_cmd = {OP_HORZ, (dx[2] ? HEAD_W : HEAD_E), 1'b0, mag_x};
   end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as leg commands, otherwise passes BLE commands through.
module tour_cmd
   import tour_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   state_t      state;
   state_t      next;
   logic [15:0] vert_cmd;
   logic [15:0] horz_cmd;
   logic        move_valid;
   logic        clr_indx;
   logic        inc_indx;

   knight_move_decode u_decode (
      .move     (move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd),
      .valid    (move_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mv_indx <= '0;
      end else begin
         state <= next;
         if (clr_indx)
            mv_indx <= '0;
         else if (inc_indx)
            mv_indx <= mv_indx + 5'd1;
      end
   end

   always_comb begin
      next             = state;
      cmd              = vert_cmd;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_ACK;
      clr_indx         = 1'b0;
      inc_indx         = 1'b0;
      case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
            if (start_tour) begin
               clr_indx = 1'b1;
               next     = VERT;
            end
         end
         VERT: begin
            // An empty move entry marks the end of the tour.
            if (!move_valid)
               next = IDLE;
            else begin
               cmd_rdy = 1'b1;
               if (clr_cmd_rdy)
                  next = WAIT_V;
            end
         end
         WAIT_V: begin
            if (send_resp)
               next = HORZ;
         end
         HORZ: begin
            cmd = horz_cmd;
            if (!move_valid)
               next = IDLE;
            else begin
               cmd_rdy = 1'b1;
               if (clr_cmd_rdy)
                  next = WAIT_H;
            end
         end
         WAIT_H: begin
            cmd = horz_cmd;
            if (mv_indx == LAST_MOVE)
               resp = RESP_DONE;
            if (send_resp) begin
               if (mv_indx == LAST_MOVE)
                  next = IDLE;
               else begin
                  inc_indx = 1'b1;
                  next     = VERT;
               end
            end
         end
         default: next = IDLE;
      endcase
   end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 clk  input  1  system clock, all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start_tour  input  1  one-cycle pulse that starts replay of a solved tour.
REQ-004 move  input  8  one-hot knight move for entry mv_indx, from external tour memory.
REQ-005 mv_indx  output  5  index of the move being replayed, 0..23.
REQ-006 cmd_UART  input  16  command from BLE receiver.
REQ-007 cmd_rdy_UART  input  1  BLE command valid.
REQ-008 clr_cmd_rdy_UART  output  1  consume BLE command.
REQ-009 cmd  output  16  command to command processor.
REQ-010 cmd_rdy  output  1  command to command processor valid.
REQ-011 clr_cmd_rdy  input  1  command processor consumed cmd.
REQ-012 send_resp  input  1  command processor finished a command.
REQ-013 resp  output  8  response byte sent with send_resp.

Function
REQ-014 Command format: [15:12] opcode, [11:4] heading, [3:0] squares; move opcode 4'b0100 (vertical leg, no fanfare), 4'b0101 (horizontal leg, fanfare).
REQ-015 Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-016 Move decode (dx,dy): bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1); +x east, +y north.
REQ-017 Multi-hot move: lowest set bit wins; all-zero move: tour ends, go IDLE, no command issued.
REQ-018 Vertical leg cmd = {4'b0100, N or S heading, |dy|}; horizontal leg cmd = {4'b0101, E or W heading, |dx|}.
REQ-019 States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
REQ-020 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy; start_tour -> VERT with mv_indx cleared to 0.
REQ-021 VERT: cmd_rdy=1, vertical cmd; clr_cmd_rdy -> WAIT_V.
REQ-022 WAIT_V: cmd_rdy=0; send_resp -> HORZ.
REQ-023 HORZ: cmd_rdy=1, horizontal cmd; clr_cmd_rdy -> WAIT_H.
REQ-024 WAIT_H: send_resp with mv_indx==23 -> IDLE; otherwise mv_indx+1 and -> VERT.
REQ-025 Outside IDLE, clr_cmd_rdy_UART=0, BLE commands stay pending, and start_tour is ignored.
REQ-026 clr_cmd_rdy in WAIT_V/WAIT_H and send_resp in VERT/HORZ are ignored.
REQ-027 resp = 8'h5A in every non-IDLE state, except WAIT_H at mv_indx==23; there and in IDLE, resp = 8'hA5.
REQ-028 Latency: start_tour at cycle N gives cmd_rdy=1 at N+1; clr_cmd_rdy at N gives cmd_rdy=0 at N+1.
REQ-029 cmd, cmd_rdy and resp are combinational from state, mv_indx, move and the IDLE pass-through inputs; cmd is held stable while cmd_rdy=1.

Reset
REQ-030 rst asserted gives state IDLE and mv_indx 0 immediately, regardless of clock, including mid-tour.
REQ-031 During reset the outputs are IDLE pass-through values: cmd_rdy=cmd_rdy_UART and resp=8'hA5.

Structure
REQ-032 Package tour_pkg holds the state enum, the move opcodes, the four heading constants, the response bytes 8'hA5/8'h5A and LAST_MOVE=23.
REQ-033 One combinational sub-module, knight_move_decode: maps move[7:0] to vertical cmd, horizontal cmd and a valid flag.

Verification
REQ-034 IDLE, cmd_rdy_UART=1, cmd_UART=16'h2000 -> cmd=16'h2000, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1.
REQ-035 start_tour, move=8'h01 -> cmd=16'h4002; after clr/send_resp -> cmd=16'h5BF1.
REQ-036 move=8'h08 -> cmd=16'h47F1, then cmd=16'h53F2.
REQ-037 Full 24-move tour -> 48 commands; resp=8'h5A on the first 47 send_resp, 8'hA5 on the last; ends in IDLE with mv_indx=23.
REQ-038 rst pulse in WAIT_V at mv_indx=7 -> IDLE and mv_indx=0 at once; start_tour during a tour and cmd_rdy_UART during a tour have no effect.
REQ-039 move=8'h00 at mv_indx=3 -> IDLE with no cmd_rdy; move=8'h90 -> decoded as bit4, cmd=16'h47F2.
